// File: rtl/sam_arb_pkg.sv
// sam_arb_pkg: shared FSM state and grant encodings for sam_mem_arbiter
package sam_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_DM = 1'b1;
endpackage

// File: rtl/sam_mem_arbiter_if.sv
// sam_mem_arbiter_if: fetch, load/store and memory buses of the arbiter
// slave: arbiter view (takes if_*/dm_* requests and mem_ack/mem_rdata, drives acks, mem_* and stall)
// master: environment view (core requesters plus memory)
interface sam_mem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          if_err;
  logic          dm_req;
  logic          dm_we;
  logic [DW/8-1:0] dm_be;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;
  logic          dm_err;
  logic          mem_req;
  logic          mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          stall;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_ack, mem_rdata,
    output if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, mem_ack, mem_rdata,
    input  if_ack, if_rdata, if_err, dm_ack, dm_rdata, dm_err,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall
  );
endinterface

// File: rtl/sam_arb_watchdog.sv
// sam_arb_watchdog: counts WAIT cycles and flags the one in which TIMEOUT is reached
// ports: clk, rst (async, active-high), clear_i (zero count), enable_i (count this cycle), expired_o
module sam_arb_watchdog #(parameter int TIMEOUT = 15) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);
  if (TIMEOUT == 0) begin : g_off
    assign expired_o = 1'b0;
  end else begin : g_on
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clear_i ? '0 : enable_i ? cnt_q + CW'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
    end
    // the current cycle is the TIMEOUT-th counted one
    assign expired_o = enable_i && cnt_q == LAST;
  end
endmodule

// File: rtl/sam_mem_arbiter.sv
// sam_mem_arbiter: shares one memory port between instruction fetch (IF) and load/store (DM)
// ports: clk, RN (async, active-high reset), bus (sam_mem_arbiter_if.slave)
// params: AW, DW, TIMEOUT (0 disables the watchdog)
// SAM_ARB_RR_EN: round-robin tie-break instead of fixed DM-over-IF priority
module sam_mem_arbiter
  import sam_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic RN,
  sam_mem_arbiter_if.slave bus
);
  state_t          state_q;
  logic            gnt_q;
  logic            mem_req_q, mem_we_q;
  logic [DW/8-1:0] mem_be_q;
  logic [AW-1:0]   mem_addr_q;
  logic [DW-1:0]   mem_wdata_q;
  logic            if_ack_q, dm_ack_q, if_err_q, dm_err_q;
  logic [DW-1:0]   if_rdata_q, dm_rdata_q;
  logic            win, wd_exp, any_req, wr_ack;
  logic [DW-1:0]   rsp_data;
`ifdef SAM_ARB_RR_EN
  logic            last_q;
  assign win = (bus.if_req && bus.dm_req) ? ~last_q : bus.dm_req;
`else
  assign win = bus.dm_req;
`endif
  assign any_req  = bus.if_req || bus.dm_req;
  // acked writes leave rdata alone; a timeout returns zero
  assign wr_ack   = bus.mem_ack && mem_we_q;
  assign rsp_data = bus.mem_ack ? bus.mem_rdata : '0;
  sam_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk      (clk),
    .rst      (RN),
    .clear_i  (state_q != WAIT),
    .enable_i (state_q == WAIT),
    .expired_o(wd_exp)
  );
  always_ff @(posedge clk or posedge RN) begin
    if (RN) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_err_q    <= 1'b0;
      dm_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
`ifdef SAM_ARB_RR_EN
      last_q      <= GNT_IF;
`endif
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          gnt_q       <= win;
          mem_req_q   <= 1'b1;
          mem_we_q    <= win == GNT_DM && bus.dm_we;
          mem_be_q    <= win == GNT_DM ? bus.dm_be : '1;
          mem_addr_q  <= win == GNT_DM ? bus.dm_addr : bus.if_addr;
          mem_wdata_q <= win == GNT_DM ? bus.dm_wdata : '0;
`ifdef SAM_ARB_RR_EN
          last_q      <= win;
`endif
          state_q     <= WAIT;
        end
        WAIT: if (bus.mem_ack || wd_exp) begin
          mem_req_q <= 1'b0;
          if_ack_q  <= gnt_q == GNT_IF;
          dm_ack_q  <= gnt_q == GNT_DM;
          if_err_q  <= gnt_q == GNT_IF && !bus.mem_ack;
          dm_err_q  <= gnt_q == GNT_DM && !bus.mem_ack;
          if (!wr_ack && gnt_q == GNT_DM) dm_rdata_q <= rsp_data;
          if (!wr_ack && gnt_q == GNT_IF) if_rdata_q <= rsp_data;
          state_q   <= RESP;
        end
        default: begin
          if_ack_q <= 1'b0;
          dm_ack_q <= 1'b0;
          if_err_q <= 1'b0;
          dm_err_q <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.if_err    = if_err_q;
  assign bus.dm_err    = dm_err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.stall     = (bus.if_req & ~if_ack_q) | (bus.dm_req & ~dm_ack_q);
endmodule

// File: tb/tb_sam_mem_arbiter.sv
// tb_sam_mem_arbiter: directed and randomized transactions against a transaction-level model
module tb_sam_mem_arbiter;
  import sam_arb_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 15;
`ifdef SAM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  logic clk = 1'b0;
  logic RN = 1'b1;
  always #5 clk = ~clk;
  sam_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  sam_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (.clk(clk), .RN(RN), .bus(bus));
  int checks = 0;
  int errors = 0;
  logic last_m;
  logic [DW-1:0] if_rd_m, dm_rd_m;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // tie goes to DM, or in round-robin builds to whoever was not granted last
  function automatic logic pick(input logic ifr, input logic dmr);
    return (ifr && dmr) ? (RR ? ~last_m : GNT_DM) : dmr;
  endfunction
  task automatic rnd_fields();
    bus.if_addr  = $urandom;
    bus.dm_addr  = $urandom;
    bus.dm_wdata = $urandom;
    bus.dm_be    = 4'($urandom);
    bus.dm_we    = 1'($urandom);
  endtask
  task automatic do_reset();
    RN = 1'b1;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_be", bus.mem_be, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_acks", {bus.if_ack, bus.dm_ack, bus.if_err, bus.dm_err}, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_dm_rdata", bus.dm_rdata, 0);
    check("rst_stall", bus.stall, 0);
    RN = 1'b0;
    last_m = GNT_IF;
    if_rd_m = '0;
    dm_rd_m = '0;
    @(negedge clk);
  endtask
  // one arbitrated transaction; memory acks after lat extra WAIT cycles, never if lat >= TIMEOUT
  task automatic txn(input logic ifr, input logic dmr, input int lat, input logic [DW-1:0] rd);
    logic w, we, to;
    int n;
    w  = pick(ifr, dmr);
    we = w && bus.dm_we;
    to = lat >= TIMEOUT;
    n  = to ? TIMEOUT : lat + 1;
    bus.if_req = ifr;
    bus.dm_req = dmr;
    #1 check("stall_req", bus.stall, 1);
    @(posedge clk);
    @(negedge clk);
    for (int i = 1; i <= n; i++) begin
      check("wait_mem_req", bus.mem_req, 1);
      check("wait_mem_addr", bus.mem_addr, w ? bus.dm_addr : bus.if_addr);
      check("wait_mem_we", bus.mem_we, we);
      if (we) check("wait_mem_wdata", bus.mem_wdata, bus.dm_wdata);
      if (we) check("wait_mem_be", bus.mem_be, bus.dm_be);
      check("wait_no_ack", {bus.if_ack, bus.dm_ack}, 0);
      check("wait_stall", bus.stall, 1);
      if (i == n && !to) begin
        bus.mem_ack = 1'b1;
        bus.mem_rdata = rd;
      end
      @(posedge clk);
      @(negedge clk);
      bus.mem_ack = 1'b0;
      bus.mem_rdata = $urandom;
    end
    if (to || !we) begin
      if (w) dm_rd_m = to ? '0 : rd;
      else if_rd_m = to ? '0 : rd;
    end
    last_m = w;
    check("resp_if_ack", bus.if_ack, !w);
    check("resp_dm_ack", bus.dm_ack, w);
    check("resp_if_err", bus.if_err, !w && to);
    check("resp_dm_err", bus.dm_err, w && to);
    check("resp_if_rdata", bus.if_rdata, if_rd_m);
    check("resp_dm_rdata", bus.dm_rdata, dm_rd_m);
    check("resp_mem_req", bus.mem_req, 0);
    check("resp_stall", bus.stall, w ? ifr : dmr);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_acks", {bus.if_ack, bus.dm_ack, bus.if_err, bus.dm_err}, 0);
    check("idle_mem_req", bus.mem_req, 0);
  endtask
  initial begin
    logic [1:0] r;
    bus.if_addr = '0;
    bus.dm_addr = '0;
    bus.dm_wdata = '0;
    bus.dm_be = '0;
    bus.dm_we = 1'b0;
    do_reset();
    bus.if_addr = 32'h0000_0010;
    txn(1'b1, 1'b0, 0, 32'h0000_0093);
    bus.dm_addr = 32'h0000_0100;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.dm_be = 4'b1111;
    bus.dm_we = 1'b1;
    txn(1'b0, 1'b1, 3, 32'h1234_5678);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      rnd_fields();
      txn(1'b1, 1'b1, int'($urandom_range(0, 4)), $urandom);
    end
    bus.dm_we = 1'b0;
    txn(1'b0, 1'b1, TIMEOUT + 5, $urandom);
    txn(1'b0, 1'b1, TIMEOUT - 1, 32'hCAFE_0001);
    txn(1'b1, 1'b0, TIMEOUT, $urandom);
    rnd_fields();
    bus.dm_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_mem_req", bus.mem_req, 1);
    #2 RN = 1'b1;
    #1 check("mid_rst_mem_req", bus.mem_req, 0);
    check("mid_rst_stall_req", bus.stall, 1);
    bus.dm_req = 1'b0;
    #1 check("mid_rst_stall_idle", bus.stall, 0);
    @(negedge clk);
    RN = 1'b0;
    bus.mem_ack = 1'b1;
    last_m = GNT_IF;
    if_rd_m = '0;
    dm_rd_m = '0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      check("late_ack_ignored", {bus.if_ack, bus.dm_ack, bus.mem_req}, 0);
    end
    bus.mem_ack = 1'b0;
    check("late_dm_rdata", bus.dm_rdata, 0);
    @(negedge clk);
    for (int t = 0; t < 40; t++) begin
      r = 2'($urandom_range(1, 3));
      rnd_fields();
      txn(r[0], r[1], int'($urandom_range(0, TIMEOUT + 2)), $urandom);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
